mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit owning the HI/LO registers. It sits in the EX stage beside the ALU.
//   It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued by EX and returns HI/LO to MFHI/MFLO.
//   It exposes busy so the hazard unit stalls any MD-class instruction while an operation is in flight.
// PARAMETERS
//   MULT_CYCLES  5   cycles busy stays high after a multiply is accepted (>=1)
//   DIV_CYCLES   10  cycles busy stays high after a divide is accepted (>=1)
// PORTS
//   clk     in   1   single clock; all state updates on rising edge
//   reset   in   1   asynchronous, active-high; clears all state immediately
//   start   in   1   op valid this cycle (EX holds an MD-class instruction, not stalled)
//   op      in   4   MD operation code (encodings in mdu_pkg)
//   in1     in   32  rs operand / dividend / MTHI-MTLO source
//   in2     in   32  rt operand / divisor
//   busy    out  1   operation in flight; registered
//   out     out  32  MFHI->hi, MFLO->lo, any other op->0; combinational from op, independent of start
//   hi      out  32  current HI register
//   lo      out  32  current LO register
// BEHAVIOUR
//   Reset: busy=0, hi=0, lo=0, counter=0, state=IDLE, shadow result regs=0. Asserting reset mid-operation aborts the op with no HI/LO write.
//   FSM IDLE->BUSY: in IDLE, start=1 with MULT/MULTU/DIV/DIVU captures the result into shadow regs.
//     Counter is loaded with MULT_CYCLES or DIV_CYCLES.
//   BUSY: counter decrements each cycle; busy=1 throughout.
//     On the edge where counter reaches 0, shadow is written to hi/lo and the FSM returns to IDLE.
//   Timing: start at cycle T; busy=1 in cycles T+1..T+N; new hi/lo visible in cycle T+N+1; busy=0 in T+N+1.
//   start while BUSY: ignored entirely (no capture, no HI/LO write). Stalling the instruction is the hazard unit's job.
//   MTHI/MTLO in IDLE with start=1: hi (or lo) <= in1 at that edge, visible T+1; busy stays 0.
//   MFHI/MFLO: no state change; out reflects current hi/lo. No internal forwarding of pending results.
//   Arithmetic:
//     MULT: {hi,lo} = signed 32x32->64.
//     MULTU: {hi,lo} = unsigned 32x32->64.
//     DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
//     DIVU: unsigned quotient and remainder.
//     DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   Divisor 0 (DIV/DIVU): busy still runs DIV_CYCLES; hi/lo are left unchanged at completion.
//   Undefined op codes and NOP: no state change, out=0.
// CONFIGURATION
//   MDU_MADD_EN defined: adds MADD, MADDU, MSUB and MSUBU.
//     Each computes {hi,lo} +/- product (signed or unsigned as named), mod 2^64, using the MULT_CYCLES latency.
//     The accumulate base is the hi/lo value at acceptance.
//   MDU_MADD_EN undefined: those four codes behave as NOP (no busy, no write).
// STRUCTURE
//   mdu_pkg holds:
//     op encodings NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8,
//       MADD=9, MADDU=10, MSUB=11, MSUBU=12;
//     FSM state encoding (IDLE, BUSY);
//     counter width CNT_W = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//   One sub-module, mdu_busy_ctr: loadable down-counter with a done pulse, async active-high reset.
//   Arithmetic stays inline in mul_div_unit.
// TESTING
//   MULT in1=0xFFFFFFFE(-2), in2=3, start at T -> busy=1 T+1..T+5; T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
//   DIV in1=-7, in2=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     DIV in1=7, in2=0 -> hi/lo unchanged after 10 busy cycles.
//   MULT accepted, then DIVU with start=1 during busy -> DIVU ignored; only MULT result lands.
//     MTHI 0x1234 issued after busy drops -> hi=0x1234 next cycle, busy stays 0; MFHI op -> out=0x1234.
//   Reset pulsed in cycle T+3 of a DIV -> busy/hi/lo drop to 0 immediately.
//     A fresh MULT right after reset deasserts completes normally.
//   With MDU_MADD_EN: hi/lo=0/5, MADD 2*3 -> lo=11 after 5 cycles.
//     Without MDU_MADD_EN: same op -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// shadow-result layout and counter sizing. Optional feature macro: MDU_MADD_EN.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Result captured at acceptance and committed when the busy window closes.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } md_result_t;

  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int max_cycles;
    max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(max_cycles + 1);
  endfunction

  localparam int CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/mdu_busy_ctr.sv
// Loadable down-counter that times the busy window; done pulses on the
// decrement that takes the count from 1 to 0.
module mdu_busy_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign done = dec && !load && (count_q == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to add
// MADD/MADDU/MSUB/MSUBU; otherwise those codes are NOPs.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CTR_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  md_result_t  shadow_q, shadow_d;

  logic             ctr_load;
  logic [CTR_W-1:0] ctr_load_val;
  logic             ctr_dec;
  logic             ctr_done;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_mag_nz;
  logic [31:0] q_mag, r_mag;
  logic [31:0] div_q, div_r;
  logic [31:0] divu_den, divu_q, divu_r;

  assign prod_s = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};
  assign prod_u = {32'd0, in1} * {32'd0, in2};

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow corner
  // and gives truncation toward zero with the remainder taking the dividend's sign.
  always_comb begin
    a_neg    = in1[31];
    b_neg    = in2[31];
    a_mag    = a_neg ? (32'd0 - in1) : in1;
    b_mag    = b_neg ? (32'd0 - in2) : in2;
    b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_mag_nz;
    r_mag    = a_mag % b_mag_nz;
    div_q    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    div_r    = a_neg ? (32'd0 - r_mag) : r_mag;
    divu_den = (in2 == 32'd0) ? 32'd1 : in2;
    divu_q   = in1 / divu_den;
    divu_r   = in1 % divu_den;
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    shadow_d     = shadow_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              shadow_d     = '{hi: prod_s[63:32], lo: prod_s[31:0], we: 1'b1};
              ctr_load     = 1'b1;
              ctr_load_val = CTR_W'(MULT_CYCLES);
              state_d      = ST_BUSY;
            end
            OP_MULTU: begin
              shadow_d     = '{hi: prod_u[63:32], lo: prod_u[31:0], we: 1'b1};
              ctr_load     = 1'b1;
              ctr_load_val = CTR_W'(MULT_CYCLES);
              state_d      = ST_BUSY;
            end
            OP_DIV: begin
              shadow_d     = '{hi: div_r, lo: div_q, we: (in2 != 32'd0)};
              ctr_load     = 1'b1;
              ctr_load_val = CTR_W'(DIV_CYCLES);
              state_d      = ST_BUSY;
            end
            OP_DIVU: begin
              shadow_d     = '{hi: divu_r, lo: divu_q, we: (in2 != 32'd0)};
              ctr_load     = 1'b1;
              ctr_load_val = CTR_W'(DIV_CYCLES);
              state_d      = ST_BUSY;
            end
            OP_MTHI: hi_d = in1;
            OP_MTLO: lo_d = in1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              logic [63:0] acc;
              logic [63:0] prod;
              prod = (op == OP_MADD || op == OP_MSUB) ? prod_s : prod_u;
              acc  = (op == OP_MADD || op == OP_MADDU) ? ({hi_q, lo_q} + prod)
                                                       : ({hi_q, lo_q} - prod);
              shadow_d     = '{hi: acc[63:32], lo: acc[31:0], we: 1'b1};
              ctr_load     = 1'b1;
              ctr_load_val = CTR_W'(MULT_CYCLES);
              state_d      = ST_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        ctr_dec = 1'b1;
        if (ctr_done) begin
          state_d = ST_IDLE;
          if (shadow_q.we) begin
            hi_d = shadow_q.hi;
            lo_d = shadow_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_busy_ctr #(
    .CNT_W(CTR_W)
  ) u_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (ctr_load),
    .load_val(ctr_load_val),
    .dec     (ctr_dec),
    .done    (ctr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    case (op)
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed vectors covering latency,
// signed/unsigned arithmetic, divide-by-zero, busy-ignore, moves and reset abort.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .out  (out),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    step();
    start = 1'b0;
    op    = OP_NOP;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NOP;
    in1   = '0;
    in2   = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_out", out, 32'd0);
    step();
    reset = 1'b0;
    step();

    // MULT -2 * 3: busy for exactly 5 cycles, no early visibility
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy_c%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("mult_lo_hold_c%0d", i), lo, 32'd0);
      step();
    end
    check("mult_busy_done", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) step();
    check("multu_busy_done", {31'd0, busy}, 32'd0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2: 10 busy cycles
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) step();
    check("div_busy_c10", {31'd0, busy}, 32'd1);
    check("div_hi_hold_c10", hi, 32'hFFFF_FFFE);
    step();
    check("div_busy_done", {31'd0, busy}, 32'd0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIV by zero: full busy window, HI/LO untouched
    issue(OP_DIV, 32'd7, 32'd0);
    repeat (9) step();
    check("div0_busy_c10", {31'd0, busy}, 32'd1);
    step();
    check("div0_busy_done", {31'd0, busy}, 32'd0);
    check("div0_lo", lo, 32'hFFFF_FFFD);
    check("div0_hi", hi, 32'hFFFF_FFFF);

    // Signed overflow corner
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) step();
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // DIVU with top bit set in the dividend
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    repeat (10) step();
    check("divu_lo", lo, 32'h0FFF_FFFF);
    check("divu_hi", hi, 32'h0000_000F);

    // MULT then DIVU and MTLO issued while busy: both ignored
    issue(OP_MULT, 32'd7, 32'd6);
    step();
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("ign_busy_c4", {31'd0, busy}, 32'd1);
    check("ign_lo_hold", lo, 32'h0FFF_FFFF);
    step();
    check("ign_busy_c5", {31'd0, busy}, 32'd1);
    step();
    check("ign_busy_done", {31'd0, busy}, 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd42);
    step();
    check("ign_no_retrigger", {31'd0, busy}, 32'd0);
    check("ign_lo_stable", lo, 32'd42);

    // MTHI and MFHI/MFLO/out decode
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_lo_kept", lo, 32'd42);
    op = OP_MFHI;
    #1;
    check("mfhi_out", out, 32'h0000_1234);
    op = OP_MFLO;
    #1;
    check("mflo_out", out, 32'd42);
    op = OP_MULT;
    #1;
    check("other_op_out", out, 32'd0);
    op = 4'd15;
    #1;
    check("undef_op_out", out, 32'd0);
    issue(4'd15, 32'h5555_5555, 32'h1);
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h0000_1234);
    op = OP_NOP;

    // Reset in cycle T+3 of a DIV aborts immediately
    issue(OP_DIV, 32'd100, 32'd7);
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    check("abort_lo_idle", lo, 32'd0);

    // Fresh MULT after reset
    issue(OP_MULT, 32'd3, 32'd4);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    repeat (5) step();
    check("post_rst_done", {31'd0, busy}, 32'd0);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_hi", hi, 32'd0);

    // Multiply-accumulate: base hi/lo = 0/5
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
    check("madd_busy", {31'd0, busy}, 32'd1);
    repeat (5) step();
    check("madd_done", {31'd0, busy}, 32'd0);
    check("madd_lo", lo, 32'd11);
    check("madd_hi", hi, 32'd0);
    issue(OP_MSUBU, 32'd4, 32'd4);
    repeat (5) step();
    check("msubu_lo", lo, 32'hFFFF_FFFB);
    check("msubu_hi", hi, 32'hFFFF_FFFF);
`else
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();
    check("madd_off_busy_late", {31'd0, busy}, 32'd0);
    check("madd_off_lo", lo, 32'd5);
    check("madd_off_hi", hi, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
